fir_serial_mc: RTL and testbench

//  Multi-channel, time-multiplexed FIR filter using one signed MAC.
//  - Coefficients are runtime-loadable; outputs are rounded and saturated.
//  - Replaces the fully parallel single-channel FIR in the audio/decimation chain.
//  - Uses a valid/ready handshake on both sides, so it can sit between rate-converted

---
 rtl/fir_serial_mc.sv | 184 ++++++++++++++++++
 tb/tb_fir_serial_mc.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_serial_mc.sv
// Multi-channel time-multiplexed FIR: one signed MAC shared by all channels and taps,
// runtime-loadable coefficients, rounded and saturated output, valid/ready on both sides.
module fir_serial_mc #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned COEF_WIDTH = 16,
   parameter int unsigned TAPS       = 30,
   parameter int unsigned CHANNELS   = 2,
   parameter int unsigned OUT_WIDTH  = 16,
   parameter int unsigned SHIFT      = 15,
   localparam int unsigned CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int unsigned AW        = $clog2(TAPS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [CW-1:0]                s_chan,
   input  logic signed [WIDTH-1:0]      s_data,
   output logic                         s_err,
   input  logic                         coef_we,
   input  logic [AW-1:0]                coef_addr,
   input  logic signed [COEF_WIDTH-1:0] coef_data,
   output logic                         coef_busy,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [CW-1:0]                m_chan,
   output logic signed [OUT_WIDTH-1:0]  m_data,
   output logic                         m_sat,
   output logic                         m_primed
);

   localparam int unsigned PW        = WIDTH + COEF_WIDTH;
   localparam int unsigned ACC_WIDTH = PW + $clog2(TAPS);
   localparam int unsigned RW        = ACC_WIDTH + 1;
   localparam int unsigned FW        = $clog2(TAPS + 1);

   localparam logic signed [RW-1:0] RND  = RW'(64'd1 << (SHIFT - 1));
   localparam logic signed [RW-1:0] OMAX = RW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
   localparam logic signed [RW-1:0] OMIN = ~OMAX;

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;

   state_t                         r_state;
   logic signed [WIDTH-1:0]        r_buf    [CHANNELS][TAPS];
   logic [AW-1:0]                  r_wr_ptr [CHANNELS];
   logic [FW-1:0]                  r_fill   [CHANNELS];
   logic signed [COEF_WIDTH-1:0]   r_coef   [TAPS];
   logic signed [ACC_WIDTH-1:0]    r_acc;
   logic [AW-1:0]                  r_k;
   logic [CW-1:0]                  r_ch;

   logic                           r_s_ready;
   logic                           r_s_err;
   logic                           r_coef_busy;
   logic                           r_m_valid;
   logic [CW-1:0]                  r_m_chan;
   logic signed [OUT_WIDTH-1:0]    r_m_data;
   logic                           r_m_sat;
   logic                           r_m_primed;

   logic                           w_chan_ok;
   logic                           w_addr_ok;
   logic [AW-1:0]                  w_ptr;
   logic [AW-1:0]                  w_rd_idx;
   logic signed [PW-1:0]           w_prod;
   logic signed [RW-1:0]           w_rsum;
   logic signed [RW-1:0]           w_rsh;
   logic signed [OUT_WIDTH-1:0]    w_out;
   logic                           w_sat;

   assign w_chan_ok = (32'(s_chan) < CHANNELS);
   assign w_addr_ok = (32'(coef_addr) < TAPS);

   // Tap k reads the sample written k accepts ago: (wr_ptr - k) mod TAPS
   assign w_ptr = r_wr_ptr[r_ch];
   always_comb begin
      w_rd_idx = w_ptr - r_k;
      if (w_ptr < r_k) begin
         w_rd_idx = AW'(w_ptr + AW'(TAPS) - r_k);
      end
   end

   assign w_prod = PW'(r_buf[r_ch][w_rd_idx]) * PW'(r_coef[r_k]);

   // Round half up, arithmetic shift, then clip to the output range
   assign w_rsum = RW'(r_acc) + RND;
   assign w_rsh  = w_rsum >>> SHIFT;

   always_comb begin
      w_sat = 1'b0;
      w_out = OUT_WIDTH'(w_rsh);
      if (w_rsh > OMAX) begin
         w_sat = 1'b1;
         w_out = OUT_WIDTH'(OMAX);
      end else if (w_rsh < OMIN) begin
         w_sat = 1'b1;
         w_out = OUT_WIDTH'(OMIN);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_buf       <= '{default: '0};
         r_wr_ptr    <= '{default: '0};
         r_fill      <= '{default: '0};
         r_coef      <= '{default: '0};
         r_acc       <= '0;
         r_k         <= '0;
         r_ch        <= '0;
         r_s_ready   <= 1'b1;
         r_s_err     <= 1'b0;
         r_coef_busy <= 1'b0;
         r_m_valid   <= 1'b0;
         r_m_chan    <= '0;
         r_m_data    <= '0;
         r_m_sat     <= 1'b0;
         r_m_primed  <= 1'b0;
      end else begin
         r_s_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (coef_we && w_addr_ok) begin
                  r_coef[coef_addr] <= coef_data;
               end
               if (s_valid) begin
                  if (w_chan_ok) begin
                     r_buf[s_chan][r_wr_ptr[s_chan]] <= s_data;
                     r_ch        <= s_chan;
                     r_acc       <= '0;
                     r_k         <= '0;
                     r_s_ready   <= 1'b0;
                     r_coef_busy <= 1'b1;
                     r_state     <= S_MAC;
                  end else begin
                     r_s_err <= 1'b1;
                  end
               end
            end
            S_MAC: begin
               r_acc <= r_acc + ACC_WIDTH'(w_prod);
               if (r_k == AW'(TAPS - 1)) begin
                  r_wr_ptr[r_ch] <= (w_ptr == AW'(TAPS - 1)) ? '0 : w_ptr + AW'(1);
                  if (r_fill[r_ch] != FW'(TAPS)) begin
                     r_fill[r_ch] <= r_fill[r_ch] + FW'(1);
                  end
                  r_state <= S_ROUND;
               end else begin
                  r_k <= r_k + AW'(1);
               end
            end
            S_ROUND: begin
               r_m_data   <= w_out;
               r_m_sat    <= w_sat;
               r_m_chan   <= r_ch;
               r_m_primed <= (r_fill[r_ch] == FW'(TAPS));
               r_m_valid  <= 1'b1;
               r_state    <= S_OUT;
            end
            S_OUT: begin
               if (m_ready) begin
                  r_m_valid   <= 1'b0;
                  r_s_ready   <= 1'b1;
                  r_coef_busy <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign s_ready   = r_s_ready;
   assign s_err     = r_s_err;
   assign coef_busy = r_coef_busy;
   assign m_valid   = r_m_valid;
   assign m_chan    = r_m_chan;
   assign m_data    = r_m_data;
   assign m_sat     = r_m_sat;
   assign m_primed  = r_m_primed;

endmodule

// File: tb/tb_fir_serial_mc.sv
// Bench for fir_serial_mc: per-channel sample history model, scoreboard of expected results,
// directed impulse/saturation/backpressure/reset scenarios followed by randomized traffic.
module tb_fir_serial_mc;

   localparam int TAPS = 30;
   localparam int CH   = 3;   // three channels so that an out-of-range index (3) is representable
   localparam int CW   = 2;
   localparam int AW   = 5;

   typedef struct {
      int data;
      int chan;
      int sat;
      int primed;
   } res_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 s_valid = 1'b0;
   logic                 s_ready;
   logic [CW-1:0]        s_chan = '0;
   logic signed [15:0]   s_data = '0;
   logic                 s_err;
   logic                 coef_we = 1'b0;
   logic [AW-1:0]        coef_addr = '0;
   logic signed [15:0]   coef_data = '0;
   logic                 coef_busy;
   logic                 m_valid;
   logic                 m_ready = 1'b1;
   logic [CW-1:0]        m_chan;
   logic signed [15:0]   m_data;
   logic                 m_sat;
   logic                 m_primed;

   int   checks = 0;
   int   errors = 0;
   int   coef_m [TAPS];
   int   hist   [CH][TAPS];
   int   cnt    [CH];
   res_t exp_q [$];
   res_t got_q [$];
   bit   rdy_rand = 1'b0;

   int   hold;
   int   hold_data, hold_chan, hold_sat, hold_primed;
   res_t mon_e, mon_g;

   fir_serial_mc #(.CHANNELS(CH)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_chan(s_chan), .s_data(s_data), .s_err(s_err),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_busy(coef_busy),
      .m_valid(m_valid), .m_ready(m_ready), .m_chan(m_chan), .m_data(m_data),
      .m_sat(m_sat), .m_primed(m_primed)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, longint act, longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Filter output as the plain convolution of the last TAPS samples of the channel
   function automatic res_t model_push(int ch, int d);
      longint acc;
      longint r;
      res_t   e;
      for (int k = TAPS - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
      hist[ch][0] = d;
      if (cnt[ch] < TAPS) cnt[ch]++;
      acc = 0;
      for (int k = 0; k < TAPS; k++) acc += longint'(hist[ch][k]) * longint'(coef_m[k]);
      r = (acc + 64'sd16384) >>> 15;
      e.sat = 0;
      if (r > 32767) begin
         r = 32767;
         e.sat = 1;
      end else if (r < -32768) begin
         r = -32768;
         e.sat = 1;
      end
      e.data   = int'(r);
      e.chan   = ch;
      e.primed = (cnt[ch] == TAPS) ? 1 : 0;
      return e;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      got_q.delete();
      for (int c = 0; c < CH; c++) begin
         cnt[c] = 0;
         for (int k = 0; k < TAPS; k++) hist[c][k] = 0;
      end
      for (int k = 0; k < TAPS; k++) coef_m[k] = 0;
   endtask

   // Result checker: every handshake is matched against the scoreboard; stalled outputs must hold
   always @(negedge clk) begin
      if (rst) begin
         hold = 0;
      end else begin
         if (hold != 0 && m_valid) begin
            chk("hold_data", m_data, hold_data);
            chk("hold_chan", m_chan, hold_chan);
            chk("hold_sat", m_sat, hold_sat);
            chk("hold_primed", m_primed, hold_primed);
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious_m_valid", m_valid, 0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("m_data", m_data, mon_e.data);
               chk("m_chan", m_chan, mon_e.chan);
               chk("m_sat", m_sat, mon_e.sat);
               chk("m_primed", m_primed, mon_e.primed);
               mon_g.data   = int'(m_data);
               mon_g.chan   = int'(m_chan);
               mon_g.sat    = int'(m_sat);
               mon_g.primed = int'(m_primed);
               got_q.push_back(mon_g);
            end
            hold = 0;
         end else begin
            hold        = m_valid ? 1 : 0;
            hold_data   = int'(m_data);
            hold_chan   = int'(m_chan);
            hold_sat    = int'(m_sat);
            hold_primed = int'(m_primed);
         end
      end
   end

   always @(posedge clk) begin
      #2;
      if (rdy_rand) m_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic send(int ch, int d);
      int n;
      @(negedge clk);
      s_valid = 1'b1;
      s_chan  = CW'(ch);
      s_data  = 16'(d);
      n = 0;
      while (!s_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) chk("s_ready_timeout", s_ready, 1);
      @(posedge clk);
      if (ch < CH) exp_q.push_back(model_push(ch, d));
      @(negedge clk);
      s_valid = 1'b0;
      if (ch < CH) begin
         chk("busy_after_accept", coef_busy, 1);
      end else begin
         chk("s_err_pulse", s_err, 1);
         chk("s_err_no_busy", coef_busy, 0);
         @(negedge clk);
         chk("s_err_clear", s_err, 0);
      end
   endtask

   task automatic wr_coef(int a, int v);
      @(negedge clk);
      coef_we   = 1'b1;
      coef_addr = AW'(a);
      coef_data = 16'(v);
      if (a < TAPS) coef_m[a] = v;
      @(negedge clk);
      coef_we = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || m_valid) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) chk("drain_timeout", exp_q.size(), 0);
      @(negedge clk);
   endtask

   task automatic set_ready(logic v);
      rdy_rand = 1'b0;
      @(posedge clk);
      #2 m_ready = v;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_coef_busy", coef_busy, 0);
      chk("rst_s_err", s_err, 0);
      chk("rst_m_primed", m_primed, 0);
      model_reset();
      s_valid = 1'b0;
      coef_we = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic ramp_coefs();
      for (int k = 0; k < TAPS; k++) wr_coef(k, 100 * (k + 1));
   endtask

   initial begin
      int n;
      int i0, i1;
      model_reset();
      #1 rst = 1'b1;
      #1;
      chk("init_s_ready", s_ready, 1);
      chk("init_m_valid", m_valid, 0);
      chk("init_m_chan", m_chan, 0);
      chk("init_m_sat", m_sat, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Async reset while a computation is in flight
      send(1, 1234);
      repeat (5) @(negedge clk);
      pulse_reset();
      repeat (40) @(negedge clk);

      // Impulse response on channel 0
      ramp_coefs();
      got_q.delete();
      send(0, 16384);
      for (int i = 1; i < TAPS; i++) send(0, 0);
      drain();
      chk("imp_count", got_q.size(), TAPS);
      for (int i = 0; i < got_q.size(); i++) begin
         chk("imp_literal", got_q[i].data, 50 * (i + 1));
         chk("imp_primed", got_q[i].primed, (i == TAPS - 1) ? 1 : 0);
      end

      // Channel isolation with an out-of-range channel mixed in
      got_q.delete();
      for (int i = 0; i < TAPS; i++) begin
         send(0, (i == 0) ? 16384 : 0);
         send(1, 0);
         if (i == 15) send(3, 777);
      end
      drain();
      i0 = 0;
      i1 = 0;
      for (int i = 0; i < got_q.size(); i++) begin
         if (got_q[i].chan == 0) begin
            chk("iso_ch0", got_q[i].data, 50 * (i0 + 1));
            i0++;
         end else begin
            chk("iso_ch1", got_q[i].data, 0);
            chk("iso_ch1_primed", got_q[i].primed, (i1 == TAPS - 1) ? 1 : 0);
            i1++;
         end
      end
      chk("iso_count", got_q.size(), 2 * TAPS);

      // Backpressure: result held, sample held off, coefficient write dropped while busy
      set_ready(1'b0);
      send(0, 1000);
      n = 0;
      while (!m_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp_m_valid_rise", m_valid, 1);
      @(negedge clk);
      s_valid   = 1'b1;
      s_chan    = CW'(1);
      s_data    = 16'(555);
      coef_we   = 1'b1;
      coef_addr = '0;
      coef_data = 16'(7777);
      @(negedge clk);
      coef_we = 1'b0;
      for (int i = 0; i < 50; i++) begin
         chk("bp_s_ready", s_ready, 0);
         chk("bp_coef_busy", coef_busy, 1);
         chk("bp_m_valid", m_valid, 1);
         @(negedge clk);
      end
      set_ready(1'b1);
      n = 0;
      while (!s_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("bp_release", s_ready, 1);
      @(posedge clk);
      exp_q.push_back(model_push(1, 555));
      @(negedge clk);
      s_valid = 1'b0;
      drain();
      got_q.delete();
      send(2, 16384);
      drain();
      chk("bp_coef_readback", got_q[0].data, 50);

      // Saturation in both directions
      for (int k = 0; k < TAPS; k++) wr_coef(k, 32767);
      got_q.delete();
      for (int i = 0; i < TAPS; i++) send(1, 32767);
      for (int i = 0; i < TAPS; i++) send(1, -32768);
      drain();
      chk("sat_pos_data", got_q[TAPS-1].data, 32767);
      chk("sat_pos_flag", got_q[TAPS-1].sat, 1);
      chk("sat_neg_data", got_q[2*TAPS-1].data, -32768);
      chk("sat_neg_flag", got_q[2*TAPS-1].sat, 1);

      // Reset during tap 10 of the MAC, then a clean impulse
      send(0, 500);
      repeat (10) @(posedge clk);
      pulse_reset();
      repeat (40) @(negedge clk);
      chk("post_rst_no_valid", m_valid, 0);
      wr_coef(0, 2);
      got_q.delete();
      send(0, 16384);
      drain();
      chk("post_rst_impulse", got_q[0].data, 1);
      chk("post_rst_primed", got_q[0].primed, 0);

      // Randomized traffic with random backpressure
      for (int k = 0; k < TAPS; k++) wr_coef(k, int'($urandom_range(0, 65535)) - 32768);
      rdy_rand = 1'b1;
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 15) == 0) send(3, int'($urandom_range(0, 65535)) - 32768);
         else send(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 65535)) - 32768);
         if (i == 60) begin
            drain();
            for (int k = 0; k < TAPS; k++) wr_coef(k, int'($urandom_range(0, 4095)) - 2048);
         end
      end
      drain();
      set_ready(1'b1);
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1);
   end

endmodule
